serial_pattern_generator_using_fsm: RTL

FSM-based serial bit-sequence transmitter. It accepts a parallel pattern and a repeat count through a valid/ready handshake, then shifts the pattern out MSB-first on a one-bit serial line, one bit per clock. Repetitions are separated by an optional run of idle zero cycles. The output stream feeds the team's serial sequence-detector FSMs, both as live stimulus and in directed self-checks.

---
 rtl/serial_pattern_generator_using_fsm_pkg.sv | 10 +
 rtl/serial_pattern_generator_using_fsm_if.sv | 27 ++
 rtl/serial_pattern_generator_using_fsm_pattern_shift_register.sv | 32 +++
 rtl/serial_pattern_generator_using_fsm.sv | 126 ++++++++++++
 4 files changed

// File: rtl/serial_pattern_generator_using_fsm_pkg.sv
// Shared types for the serial pattern generator: FSM state encoding.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/serial_pattern_generator_using_fsm_if.sv
// Request/response bundle of the serial pattern generator, plus FSM state for observation.
// Handshake: a request transfers on a rising edge where start_valid && start_ready;
// pattern/repeats must be stable on that edge and are don't-care afterwards.
interface serial_pattern_generator_using_fsm_if #(
  parameter int W     = 4,
  parameter int CNT_W = 4
);
  logic                      start_valid;
  logic                      start_ready;
  logic [W-1:0]              pattern;
  logic [CNT_W-1:0]          repeats;
  logic                      a;
  logic                      a_valid;
  logic                      busy;
  logic                      done;
  serial_pattern_pkg::state_e state;

  modport master (
    output start_valid, pattern, repeats,
    input  start_ready, a, a_valid, busy, done, state
  );

  modport slave (
    input  start_valid, pattern, repeats,
    output start_ready, a, a_valid, busy, done, state
  );
endinterface

// File: rtl/serial_pattern_generator_using_fsm_pattern_shift_register.sv
// Parallel-load, left-shift register; bit_o is the bit currently on the line and
// drops to 0 on any cycle that neither loads nor shifts.
module pattern_shift_register #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         bit_o
);
  logic         bit_q;
  logic [W-2:0] rest_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q  <= 1'b0;
      rest_q <= '0;
    end else if (load_i) begin
      bit_q  <= data_i[W-1];
      rest_q <= data_i[W-2:0];
    end else if (shift_i) begin
      bit_q  <= rest_q[W-2];
      rest_q <= rest_q << 1;
    end else begin
      bit_q  <= 1'b0;
    end
  end

  assign bit_o = bit_q;
endmodule

// File: rtl/serial_pattern_generator_using_fsm.sv
// Serial pattern transmitter: sends a latched W-bit pattern MSB-first, 'repeats'
// times, with GAP idle cycles between copies and a one-cycle done pulse at the end.
module serial_pattern_generator_using_fsm
  import serial_pattern_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input logic clk,
  input logic rst,
  serial_pattern_generator_using_fsm_if.slave bus
);
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [W-1:0]     pat_q, pat_d;
  logic             valid_q, busy_q, done_q, done_d;
  logic             sr_load, sr_shift;
  logic [W-1:0]     sr_data;
  logic             accept;

  assign accept = bus.start_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
    pat_d    = pat_q;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_data  = pat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pat_d = bus.pattern;
          if (bus.repeats != '0) begin
            state_d = ST_SHIFT;
            rep_d   = bus.repeats;
            bit_d   = '0;
            sr_load = 1'b1;
            sr_data = bus.pattern;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (bit_q == BIT_LAST) begin
          // rep_q counts copies still owed including this one, so it is never 0 here
          rep_d = rep_q - 1'b1;
          if (rep_q != CNT_W'(1)) begin
            if (GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else begin
              bit_d   = '0;
              sr_load = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          bit_d    = bit_q + 1'b1;
          sr_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_SHIFT;
          bit_d   = '0;
          sr_load = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      pat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      pat_q   <= pat_d;
      valid_q <= (state_d == ST_SHIFT);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  pattern_shift_register #(.W(W)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (sr_data),
    .bit_o   (bus.a)
  );

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.a_valid     = valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.state       = state_q;
endmodule
